// File: rtl/multi_blink_pkg.sv
// Shared encodings for the multi-channel LED pattern generator.
// Holds the configuration mode codes, the channel state enum and the mode-to-state mapping.
package multi_blink_pkg;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_BURST = 2'd3;

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_ON    = 2'd1,
      S_BLINK = 2'd2,
      S_BURST = 2'd3
   } ch_state_t;

   // A burst with no pulses is indistinguishable from OFF, so it is folded into OFF here.
   function automatic ch_state_t mode_to_state(input logic [1:0] mode, input logic pulses_nz);
      ch_state_t st;
      case (mode)
         MODE_OFF:   st = S_OFF;
         MODE_ON:    st = S_ON;
         MODE_BLINK: st = S_BLINK;
         MODE_BURST: st = pulses_nz ? S_BURST : S_OFF;
         default:    st = S_OFF;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/multi_blink_channel.sv
// One LED channel: mode FSM, half-period tick counter and remaining-pulse counter.
// The led and busy outputs are registered; a write always takes priority over a tick.
module blink_channel
   import multi_blink_pkg::*;
#(
   parameter int PERIOD_W = 16,
   parameter int CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick,
   input  logic                we,
   input  logic [1:0]          mode,
   input  logic [PERIOD_W-1:0] period,
   input  logic [CNT_W-1:0]    pulses,
   output logic                led,
   output logic                busy
);

   ch_state_t           state_r, state_s;
   logic [PERIOD_W-1:0] cnt_r, cnt_s;
   logic [PERIOD_W-1:0] period_r, period_s;
   logic [CNT_W-1:0]    remaining_r, remaining_s;
   logic                led_r, led_s;
   logic                busy_r, busy_s;
   logic                wrap_s;
   logic                burst_done_s;

   assign wrap_s       = tick && (cnt_r == (period_r - PERIOD_W'(1)));
   assign burst_done_s = wrap_s && !led_r && (remaining_r == CNT_W'(0));

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= S_OFF;
         cnt_r       <= '0;
         period_r    <= PERIOD_W'(1);
         remaining_r <= '0;
         led_r       <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         period_r    <= period_s;
         remaining_r <= remaining_s;
         led_r       <= led_s;
         busy_r      <= busy_s;
      end
   end

   // Next-state selection
   always_comb begin
      state_s = state_r;
      if (we) begin
         state_s = mode_to_state(mode, pulses != CNT_W'(0));
      end else if (state_r == S_BURST && burst_done_s) begin
         state_s = S_OFF;
      end else begin
         state_s = state_r;
      end
   end

   // Output and counter updates
   always_comb begin
      cnt_s       = cnt_r;
      period_s    = period_r;
      remaining_s = remaining_r;
      led_s       = led_r;
      busy_s      = busy_r;
      if (we) begin
         cnt_s       = '0;
         period_s    = (period == PERIOD_W'(0)) ? PERIOD_W'(1) : period;
         remaining_s = pulses;
         led_s       = (state_s != S_OFF);
         busy_s      = (state_s == S_BURST);
      end else begin
         case (state_r)
            S_BLINK: begin
               if (wrap_s) begin
                  cnt_s = '0;
                  led_s = !led_r;
               end else if (tick) begin
                  cnt_s = cnt_r + PERIOD_W'(1);
               end else begin
                  cnt_s = cnt_r;
               end
            end
            S_BURST: begin
               if (wrap_s) begin
                  cnt_s = '0;
                  if (led_r) begin
                     led_s       = 1'b0;
                     remaining_s = remaining_r - CNT_W'(1);
                  end else if (remaining_r == CNT_W'(0)) begin
                     // Off-phase after the last pulse has completed
                     led_s  = 1'b0;
                     busy_s = 1'b0;
                  end else begin
                     led_s = 1'b1;
                  end
               end else if (tick) begin
                  cnt_s = cnt_r + PERIOD_W'(1);
               end else begin
                  cnt_s = cnt_r;
               end
            end
            default: begin
               cnt_s = '0;
            end
         endcase
      end
   end

   assign led  = led_r;
   assign busy = busy_r;

endmodule

// File: rtl/multi_blink.sv
// Multi-channel LED pattern generator: shared tick prescaler plus CHANNELS
// independently configured blink_channel instances.
module multi_blink
   import multi_blink_pkg::*;
#(
   parameter int CLK_HZ   = 50000000,
   parameter int TICK_HZ  = 1000,
   parameter int CHANNELS = 4,
   parameter int PERIOD_W = 16,
   parameter int CNT_W    = 8,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [CNT_W-1:0]    cfg_pulses,
   output logic [CHANNELS-1:0] led,
   output logic [CHANNELS-1:0] busy,
   output logic                tick
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int PRE_W = $clog2(DIV);

   logic [PRE_W-1:0]    pre_cnt_r, pre_cnt_s;
   logic                tick_r;
   logic [CHANNELS-1:0] we_s;

   // Prescaler wrap
   always_comb begin
      if (pre_cnt_r == PRE_W'(DIV - 1)) begin
         pre_cnt_s = '0;
      end else begin
         pre_cnt_s = pre_cnt_r + PRE_W'(1);
      end
   end

   // Prescaler and tick registers; tick is high exactly while the count sits at DIV-1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt_r <= '0;
         tick_r    <= 1'b0;
      end else begin
         pre_cnt_r <= pre_cnt_s;
         tick_r    <= (pre_cnt_s == PRE_W'(DIV - 1));
      end
   end

   assign tick = tick_r;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      // Indices at or above CHANNELS never match, so such writes are dropped
      assign we_s[i] = cfg_we && (cfg_ch == CH_W'(i));

      blink_channel #(
         .PERIOD_W (PERIOD_W),
         .CNT_W    (CNT_W)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .tick   (tick_r),
         .we     (we_s[i]),
         .mode   (cfg_mode),
         .period (cfg_period),
         .pulses (cfg_pulses),
         .led    (led[i]),
         .busy   (busy[i])
      );
   end

endmodule
